// File: rtl/l2_dir.sv
// l2_dir: directory controller for a two-core L2 with 32 tagged lines.
// Serves one core request at a time and sequences memory, forward and invalidate traffic.
`ifndef CCP_DEFINE_H
`define CCP_DEFINE_H
`define MSG_WIDTH 8
`define DATA_WIDTH 32
`define TAG_WIDTH 5
`define OWNER_BITS 1
`define DIR_WIDTH 2
`define MESI_WIDTH 2
`define TAG_ARRAY 32
`define MSG_TYPE_EMPTY 8'd0
`define MSG_TYPE_LOAD_REQ 8'd1
`define MSG_TYPE_STORE_REQ 8'd2
`define MSG_TYPE_DATA_ACK 8'd3
`define MSG_TYPE_LOAD_MEM 8'd4
`define MSG_TYPE_LOAD_MEM_ACK 8'd5
`define MSG_TYPE_STORE_MEM 8'd6
`define MSG_TYPE_LOAD_FWD 8'd7
`define MSG_TYPE_STORE_FWD 8'd8
`define MSG_TYPE_LOAD_FWDACK 8'd9
`define MSG_TYPE_STORE_FWDACK 8'd10
`define MSG_TYPE_INV_FWD 8'd11
`define MSG_TYPE_INV_FWDACK 8'd12
`define MESI_I 2'd0
`define MESI_S 2'd1
`define MESI_E 2'd2
`define MESI_M 2'd3
`define DIR_I 2'd0
`define DIR_S 2'd1
`define DIR_EM 2'd2
`endif

module l2_dir (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`MSG_WIDTH-1:0]  msg1_type,
   input  logic [`DATA_WIDTH-1:0] msg1_data,
   input  logic [`TAG_WIDTH-1:0]  msg1_tag,
   input  logic [`OWNER_BITS-1:0] msg1_source,
   output logic                   msg1_ready,
   input  logic [`MSG_WIDTH-1:0]  msg3_type,
   input  logic [`DATA_WIDTH-1:0] msg3_data,
   input  logic [`TAG_WIDTH-1:0]  msg3_tag,
   input  logic [`OWNER_BITS-1:0] msg3_source,
   output logic [`MSG_WIDTH-1:0]  msg2_type,
   output logic [`DATA_WIDTH-1:0] msg2_data,
   output logic [`TAG_WIDTH-1:0]  msg2_tag,
   output logic [`TAG_WIDTH-1:0]  msg2_load_tag,
   output logic [`MESI_WIDTH-1:0] mesi_send,
   output logic [`OWNER_BITS-1:0] cache_owner,
   output logic [`DIR_WIDTH-1:0]  share_list
);
   typedef enum logic [2:0] {IDLE, MEM_WAIT, FWD_WAIT, INV_WAIT, RESP} state_t;
   state_t state, state_nxt;

   logic [`TAG_ARRAY-1:0]  l2_valid;
   logic [1:0]             dir_state [`TAG_ARRAY];
   logic [`OWNER_BITS-1:0] owner     [`TAG_ARRAY];
   logic [`DIR_WIDTH-1:0]  sharers   [`TAG_ARRAY];
   logic [`DATA_WIDTH-1:0] data      [`TAG_ARRAY];

   logic                   req_store;
   logic                   req_fwd;
   logic [`TAG_WIDTH-1:0]  req_tag;
   logic [`OWNER_BITS-1:0] req_src;
   logic [`DIR_WIDTH-1:0]  pending;

   logic is_load, is_store, fwd_need, inv_need;
   logic tag_hit, mem_ack, fwd_ack, inv_ack, data_we;
   logic [`DIR_WIDTH-1:0] src_bit, inv_mask, ack_bit, req_bit, old_bit;
   logic unused_msg1;

   assign unused_msg1 = ^msg1_data;

   assign is_load    = msg1_type == `MSG_TYPE_LOAD_REQ;
   assign is_store   = msg1_type == `MSG_TYPE_STORE_REQ;
   assign msg1_ready = (state == IDLE) && (is_load || is_store);

   assign src_bit  = `DIR_WIDTH'(1) << msg1_source;
   assign inv_mask = sharers[msg1_tag] & ~src_bit;
   assign fwd_need = dir_state[msg1_tag] == `DIR_EM &&
                     owner[msg1_tag] != msg1_source;
   assign inv_need = dir_state[msg1_tag] == `DIR_S &&
                     is_store && inv_mask != '0;

   assign ack_bit = `DIR_WIDTH'(1) << msg3_source;
   assign req_bit = `DIR_WIDTH'(1) << req_src;
   assign old_bit = `DIR_WIDTH'(1) << owner[req_tag];

   assign tag_hit = msg3_tag == req_tag;
   assign mem_ack = msg3_type == `MSG_TYPE_LOAD_MEM_ACK && tag_hit;
   assign fwd_ack = (msg3_type == `MSG_TYPE_LOAD_FWDACK ||
                     msg3_type == `MSG_TYPE_STORE_FWDACK) &&
                    tag_hit && msg3_source == owner[req_tag];
   assign inv_ack = msg3_type == `MSG_TYPE_INV_FWDACK && tag_hit &&
                    (pending & ack_bit) != '0;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (msg1_ready) begin
            if (!l2_valid[msg1_tag]) state_nxt = MEM_WAIT;
            else if (fwd_need)       state_nxt = FWD_WAIT;
            else if (inv_need)       state_nxt = INV_WAIT;
            else                     state_nxt = RESP;
         end
         MEM_WAIT: if (mem_ack) state_nxt = RESP;
         FWD_WAIT: if (fwd_ack) state_nxt = RESP;
         INV_WAIT:
            if (inv_ack && (pending & ~ack_bit) == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign data_we = !rst && ((state == MEM_WAIT && mem_ack) ||
                             (state == FWD_WAIT && fwd_ack));

   // Line data is never reset; l2_valid guards every read of it.
   always_ff @(posedge clk) begin
      if (data_we) data[req_tag] <= msg3_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_store <= 1'b0;
         req_fwd   <= 1'b0;
         req_tag   <= '0;
         req_src   <= '0;
         pending   <= '0;
         l2_valid  <= '0;
         for (int i = 0; i < `TAG_ARRAY; i++) begin
            dir_state[i] <= `DIR_I;
            owner[i]     <= '0;
            sharers[i]   <= '0;
         end
         msg2_type     <= `MSG_TYPE_EMPTY;
         msg2_data     <= '0;
         msg2_tag      <= '0;
         msg2_load_tag <= '0;
         mesi_send     <= `MESI_I;
         cache_owner   <= '0;
         share_list    <= '0;
      end else begin
         state      <= state_nxt;
         msg2_type  <= `MSG_TYPE_EMPTY;
         share_list <= '0;
         unique case (state)
            IDLE: if (msg1_ready) begin
               req_store <= is_store;
               req_tag   <= msg1_tag;
               req_src   <= msg1_source;
               req_fwd   <= 1'b0;
               pending   <= '0;
               if (state_nxt == MEM_WAIT) begin
                  msg2_type     <= `MSG_TYPE_LOAD_MEM;
                  msg2_tag      <= msg1_tag;
                  msg2_load_tag <= msg1_tag;
               end else if (state_nxt == FWD_WAIT) begin
                  msg2_type   <= is_store ? `MSG_TYPE_STORE_FWD
                                          : `MSG_TYPE_LOAD_FWD;
                  msg2_tag    <= msg1_tag;
                  cache_owner <= owner[msg1_tag];
                  req_fwd     <= 1'b1;
               end else if (state_nxt == INV_WAIT) begin
                  msg2_type  <= `MSG_TYPE_INV_FWD;
                  msg2_tag   <= msg1_tag;
                  share_list <= inv_mask;
                  pending    <= inv_mask;
               end
            end
            MEM_WAIT: if (mem_ack) begin
               l2_valid[req_tag]  <= 1'b1;
               dir_state[req_tag] <= `DIR_I;
            end
            FWD_WAIT: ;
            INV_WAIT: if (inv_ack) pending <= pending & ~ack_bit;
            RESP: begin
               msg2_type   <= `MSG_TYPE_DATA_ACK;
               msg2_data   <= data[req_tag];
               msg2_tag    <= req_tag;
               cache_owner <= req_src;
               if (req_store) begin
                  mesi_send          <= `MESI_M;
                  dir_state[req_tag] <= `DIR_EM;
                  owner[req_tag]     <= req_src;
                  sharers[req_tag]   <= '0;
               end else if (req_fwd) begin
                  // The previous owner keeps a shared copy after forwarding.
                  mesi_send          <= `MESI_S;
                  dir_state[req_tag] <= `DIR_S;
                  sharers[req_tag]   <= sharers[req_tag] | req_bit | old_bit;
               end else if (dir_state[req_tag] == `DIR_I) begin
                  mesi_send          <= `MESI_E;
                  dir_state[req_tag] <= `DIR_EM;
                  owner[req_tag]     <= req_src;
                  sharers[req_tag]   <= '0;
               end else if (dir_state[req_tag] == `DIR_S) begin
                  mesi_send        <= `MESI_S;
                  sharers[req_tag] <= sharers[req_tag] | req_bit;
               end else begin
                  mesi_send <= `MESI_E;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_l2_dir.sv
// tb_l2_dir: randomized scoreboard bench for l2_dir with a transaction-level
// directory model and an environment that plays memory and both cores.
`ifndef CCP_DEFINE_H
`define CCP_DEFINE_H
`define MSG_WIDTH 8
`define DATA_WIDTH 32
`define TAG_WIDTH 5
`define OWNER_BITS 1
`define DIR_WIDTH 2
`define MESI_WIDTH 2
`define TAG_ARRAY 32
`define MSG_TYPE_EMPTY 8'd0
`define MSG_TYPE_LOAD_REQ 8'd1
`define MSG_TYPE_STORE_REQ 8'd2
`define MSG_TYPE_DATA_ACK 8'd3
`define MSG_TYPE_LOAD_MEM 8'd4
`define MSG_TYPE_LOAD_MEM_ACK 8'd5
`define MSG_TYPE_STORE_MEM 8'd6
`define MSG_TYPE_LOAD_FWD 8'd7
`define MSG_TYPE_STORE_FWD 8'd8
`define MSG_TYPE_LOAD_FWDACK 8'd9
`define MSG_TYPE_STORE_FWDACK 8'd10
`define MSG_TYPE_INV_FWD 8'd11
`define MSG_TYPE_INV_FWDACK 8'd12
`define MESI_I 2'd0
`define MESI_S 2'd1
`define MESI_E 2'd2
`define MESI_M 2'd3
`define DIR_I 2'd0
`define DIR_S 2'd1
`define DIR_EM 2'd2
`endif

module tb_l2_dir;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  msg1_type, msg3_type, msg2_type;
   logic [31:0] msg1_data, msg3_data, msg2_data;
   logic [4:0]  msg1_tag, msg3_tag, msg2_tag, msg2_load_tag;
   logic        msg1_source, msg3_source, msg1_ready, cache_owner;
   logic [1:0]  mesi_send, share_list;

   always #5 clk = ~clk;

   l2_dir dut (
      .clk(clk), .rst(rst),
      .msg1_type(msg1_type), .msg1_data(msg1_data),
      .msg1_tag(msg1_tag), .msg1_source(msg1_source),
      .msg1_ready(msg1_ready),
      .msg3_type(msg3_type), .msg3_data(msg3_data),
      .msg3_tag(msg3_tag), .msg3_source(msg3_source),
      .msg2_type(msg2_type), .msg2_data(msg2_data),
      .msg2_tag(msg2_tag), .msg2_load_tag(msg2_load_tag),
      .mesi_send(mesi_send), .cache_owner(cache_owner),
      .share_list(share_list)
   );

   typedef struct packed {
      logic [7:0]  typ;
      logic [4:0]  tag;
      logic [31:0] data;
      logic        own;
      logic [1:0]  share;
      logic [1:0]  mesi;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   bit          m_valid   [32];
   logic [1:0]  m_dir     [32];
   logic        m_owner   [32];
   logic [1:0]  m_sharers [32];
   logic [31:0] m_data    [32];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_valid[i]   = 1'b0;
         m_dir[i]     = `DIR_I;
         m_owner[i]   = 1'b0;
         m_sharers[i] = 2'b00;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (msg2_type !== `MSG_TYPE_EMPTY) begin
            if (sb.size() == 0) begin
               check("unexpected_msg2", 64'(msg2_type), 64'(`MSG_TYPE_EMPTY));
            end else begin
               e = sb.pop_front();
               check("msg2_type", 64'(msg2_type), 64'(e.typ));
               check("msg2_tag", 64'(msg2_tag), 64'(e.tag));
               check("share_list", 64'(share_list), 64'(e.share));
               if (e.typ == `MSG_TYPE_LOAD_MEM)
                  check("load_tag", 64'(msg2_load_tag), 64'(e.tag));
               if (e.typ == `MSG_TYPE_LOAD_FWD || e.typ == `MSG_TYPE_STORE_FWD)
                  check("fwd_owner", 64'(cache_owner), 64'(e.own));
               if (e.typ == `MSG_TYPE_DATA_ACK) begin
                  check("ack_data", 64'(msg2_data), 64'(e.data));
                  check("ack_owner", 64'(cache_owner), 64'(e.own));
                  check("ack_mesi", 64'(mesi_send), 64'(e.mesi));
               end
            end
         end
      end
   end

   task automatic send3(input logic [7:0] t, input logic [4:0] tg,
                        input logic s, input logic [31:0] d);
      msg3_type = t; msg3_tag = tg; msg3_source = s; msg3_data = d;
   endtask

   // One core request from issue to DATA_ACK; env 0 hit, 1 mem, 2 fwd, 3 inv.
   task automatic txn(input bit st, input logic [4:0] tag, input logic src,
                      input logic [31:0] rdata, input bit stray, input bit do_rst);
      int         env, n;
      exp_t       e;
      logic [1:0] sbit, mask;
      logic       old_own;
      bit         bad_ready;
      logic [7:0] fack;
      sbit    = 2'b01 << src;
      mask    = m_sharers[tag] & ~sbit;
      old_own = m_owner[tag];
      fack    = st ? `MSG_TYPE_STORE_FWDACK : `MSG_TYPE_LOAD_FWDACK;
      e       = '0;
      e.tag   = tag;
      if (!m_valid[tag]) begin
         env = 1; e.typ = `MSG_TYPE_LOAD_MEM;
      end else if (m_dir[tag] == `DIR_EM && m_owner[tag] != src) begin
         env = 2; e.own = old_own;
         e.typ = st ? `MSG_TYPE_STORE_FWD : `MSG_TYPE_LOAD_FWD;
      end else if (m_dir[tag] == `DIR_S && st && mask != 2'b00) begin
         env = 3; e.typ = `MSG_TYPE_INV_FWD; e.share = mask;
      end else begin
         env = 0;
      end
      if (env != 0) sb.push_back(e);

      msg1_type   = st ? `MSG_TYPE_STORE_REQ : `MSG_TYPE_LOAD_REQ;
      msg1_tag    = tag;
      msg1_source = src;
      msg1_data   = $urandom;
      n = 0;
      #1;
      while (!msg1_ready && n < 50) begin @(negedge clk); #1; n++; end
      if (!msg1_ready) begin
         $display("FAIL issue_timeout: msg1_ready stayed 0");
         $fatal(1);
      end
      @(posedge clk); #1;

      bad_ready = 1'b0;
      if (env != 0) begin
         msg1_type   = `MSG_TYPE_LOAD_REQ;
         msg1_source = ~src;
         msg1_tag    = 5'($urandom);
         n = 0;
         do begin
            @(negedge clk); n++;
            if (msg1_ready) bad_ready = 1'b1;
         end while (msg2_type === `MSG_TYPE_EMPTY && n < 20);
         if (msg2_type === `MSG_TYPE_EMPTY) begin
            $display("FAIL cmd_timeout: no command for tag %0d", tag);
            $fatal(1);
         end
         if (do_rst) begin
            rst = 1'b1;
            msg1_type = `MSG_TYPE_EMPTY;
            @(negedge clk);
            rst = 1'b0;
            check("rst_outputs",
                  64'({msg2_type, msg2_data, msg2_tag, msg2_load_tag,
                       mesi_send, cache_owner, share_list}), 64'(0));
            model_reset();
            return;
         end
         if (stray) begin
            for (int k = 0; k < 2; k++) begin
               case (env)
                  1: if (k == 0) send3(`MSG_TYPE_INV_FWDACK, tag, ~src, ~rdata);
                     else send3(`MSG_TYPE_LOAD_MEM_ACK, tag ^ 5'd1, 1'b0, ~rdata);
                  2: if (k == 0) send3(fack, tag, src, ~rdata);
                     else send3(`MSG_TYPE_LOAD_MEM_ACK, tag, old_own, ~rdata);
                  default: if (k == 0) send3(`MSG_TYPE_INV_FWDACK, tag, src, ~rdata);
                     else send3(`MSG_TYPE_INV_FWDACK, tag ^ 5'd1, ~src, ~rdata);
               endcase
               @(negedge clk);
               if (msg1_ready) bad_ready = 1'b1;
            end
         end
      end else begin
         msg1_type = `MSG_TYPE_EMPTY;
      end

      if (env == 1) begin
         m_valid[tag] = 1'b1; m_dir[tag] = `DIR_I; m_data[tag] = rdata;
      end
      if (env == 2) m_data[tag] = rdata;
      e = '0;
      e.typ = `MSG_TYPE_DATA_ACK; e.tag = tag; e.own = src;
      e.data = m_data[tag];
      if (st) begin
         e.mesi = `MESI_M; m_dir[tag] = `DIR_EM;
         m_owner[tag] = src; m_sharers[tag] = 2'b00;
      end else if (env == 2) begin
         e.mesi = `MESI_S; m_dir[tag] = `DIR_S;
         m_sharers[tag] = m_sharers[tag] | sbit | (2'b01 << old_own);
      end else if (m_dir[tag] == `DIR_I) begin
         e.mesi = `MESI_E; m_dir[tag] = `DIR_EM;
         m_owner[tag] = src; m_sharers[tag] = 2'b00;
      end else if (m_dir[tag] == `DIR_S) begin
         e.mesi = `MESI_S; m_sharers[tag] = m_sharers[tag] | sbit;
      end else begin
         e.mesi = `MESI_E;
      end
      sb.push_back(e);

      if (env == 0) begin
         n = 0;
         do begin @(negedge clk); n++; end
         while (msg2_type !== `MSG_TYPE_DATA_ACK && n < 10);
         check("hit_latency", 64'(n), 64'(2));
      end else begin
         case (env)
            1: send3(`MSG_TYPE_LOAD_MEM_ACK, tag, 1'b0, rdata);
            2: send3(fack, tag, old_own, rdata);
            default: send3(`MSG_TYPE_INV_FWDACK, tag, ~src, rdata);
         endcase
         msg1_type = `MSG_TYPE_EMPTY;
         @(negedge clk);
         msg3_type = `MSG_TYPE_EMPTY;
         check("busy_ready", 64'(bad_ready), 64'(0));
         n = 0;
         while (msg2_type !== `MSG_TYPE_DATA_ACK && n < 10) begin
            @(negedge clk); n++;
         end
         check("ack_seen", 64'(msg2_type), 64'(`MSG_TYPE_DATA_ACK));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      msg1_type = `MSG_TYPE_EMPTY; msg1_data = '0;
      msg1_tag = '0; msg1_source = 1'b0;
      send3(`MSG_TYPE_EMPTY, 5'd0, 1'b0, 32'd0);
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_outputs",
            64'({msg2_type, msg2_data, msg2_tag, msg2_load_tag,
                 mesi_send, cache_owner, share_list}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      txn(1'b0, 5'd5, 1'b0, 32'hA, 1'b1, 1'b0);
      txn(1'b0, 5'd5, 1'b1, 32'hB, 1'b1, 1'b0);
      txn(1'b1, 5'd5, 1'b0, 32'h0, 1'b1, 1'b0);
      txn(1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0);
      txn(1'b0, 5'd5, 1'b1, 32'hC, 1'b0, 1'b1);
      txn(1'b0, 5'd5, 1'b0, 32'hD, 1'b0, 1'b0);
      repeat (80)
         txn(1'($urandom_range(0, 1)), 5'(4 + $urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)), 1'b0);
      repeat (5) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/l2_dir.md
L2_DIR -- requirements
Module: l2_dir

Interface
REQ-001 The block SHALL have the following parameters, taken from the `define values in ccp_define.h (no Verilog parameters): MSG_WIDTH, DATA_WIDTH, TAG_WIDTH, OWNER_BITS=1, DIR_WIDTH=2, MESI_WIDTH, TAG_ARRAY=32; meaning: two L1.5 cores, 32 tagged lines.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- msg1_type/msg1_data/msg1_tag/msg1_source  in  MSG/DATA/TAG/OWNER  arbitrated core request.
- msg1_ready  out  1  request accepted this cycle.
- msg3_type/msg3_data/msg3_tag/msg3_source  in  MSG/DATA/TAG/OWNER  arbitrated core or memory response.
- msg2_type/msg2_data/msg2_tag/msg2_load_tag  out  MSG/DATA/TAG/TAG  command to cores or memory.
- mesi_send  out  MESI  granted state.
- cache_owner  out  OWNER  target core.
- share_list  out  DIR  INV_FWD target mask.

Function
REQ-003 The block SHALL hold, for each of the 32 tags: l2_valid, dir_state (DIR_I, DIR_S, DIR_EM), owner, sharers[1:0] and data.
REQ-004 The FSM SHALL have the states IDLE, MEM_WAIT, FWD_WAIT, INV_WAIT and RESP, and SHALL hold one transaction at a time.
REQ-005 msg1_ready SHALL be combinational, equal to 1 only in IDLE with msg1_type in {MSG_TYPE_LOAD_REQ, MSG_TYPE_STORE_REQ}.
- The sender holds msg1 until msg1_ready=1.
- Any other msg1 type is ignored.
REQ-006 On acceptance, the block SHALL latch the request type, tag and source.
REQ-007 All msg2/mesi_send/cache_owner/share_list outputs SHALL be registered.
- msg2_type is MSG_TYPE_EMPTY except for single-cycle command pulses.
- share_list is 0 except with INV_FWD.
REQ-008 From IDLE with l2_valid[tag]=0, next cycle: msg2_type=MSG_TYPE_LOAD_MEM, msg2_load_tag=tag; state -> MEM_WAIT.
REQ-009 From IDLE with dir_state DIR_I, or DIR_S with a load, or DIR_EM with owner==source: state -> RESP.
REQ-010 From IDLE with DIR_S and a store: pending = sharers & ~(1<<source).
- If pending=0: state -> RESP.
- Else: msg2_type=MSG_TYPE_INV_FWD, share_list=pending, msg2_tag=tag; state -> INV_WAIT.
REQ-011 From IDLE with DIR_EM and owner!=source: msg2_type=MSG_TYPE_LOAD_FWD (load) or MSG_TYPE_STORE_FWD (store), cache_owner=owner, msg2_tag=tag; state -> FWD_WAIT.
REQ-012 In MEM_WAIT, msg3 MSG_TYPE_LOAD_MEM_ACK with msg3_tag==tag SHALL write data[tag], set l2_valid=1 and dir_state=DIR_I; state -> RESP.
REQ-013 In FWD_WAIT, msg3 MSG_TYPE_LOAD_FWDACK or MSG_TYPE_STORE_FWDACK with source==owner and tag match SHALL write data[tag]; state -> RESP.
REQ-014 In INV_WAIT, each MSG_TYPE_INV_FWDACK with tag match SHALL clear pending[msg3_source]; when pending becomes 0: state -> RESP.
- An ack for an already-cleared bit is ignored.
REQ-015 In RESP, the block SHALL issue msg2_type=MSG_TYPE_DATA_ACK, msg2_data=data[tag], msg2_tag=tag, cache_owner=source; state -> IDLE.
REQ-016 mesi_send and the directory update in RESP SHALL be:
- load from DIR_I: MESI_E; DIR_EM, owner=source.
- load from DIR_S or after LOAD_FWD: MESI_S; DIR_S, sharers |= (1<<source), plus the old owner after a forward.
- store: MESI_M; DIR_EM, owner=source, sharers=0.
- load by the current owner: MESI_E; no change.
REQ-017 Any msg3 not matching the current wait state, tag or source SHALL be ignored, with no state change.
REQ-018 The block SHALL never issue MSG_TYPE_STORE_MEM; msg2_load_tag is don't-care except during LOAD_MEM.
REQ-019 Latency: an L2 hit to DATA_ACK SHALL take 2 cycles after acceptance; every wait state SHALL wait without a timeout.

Reset
REQ-020 While rst=1, the block SHALL:
- return the FSM to IDLE, including mid-transaction, and drop the transaction;
- clear all l2_valid, dir_state=DIR_I, sharers=0, owner=0, pending=0;
- drive msg2_type=MSG_TYPE_EMPTY, msg2_data=0, msg2_tag=0, msg2_load_tag=0, mesi_send=MESI_I, cache_owner=0, share_list=0.
- data contents need not be reset.

Verification
REQ-021 Cold load, core0 tag 5 -> LOAD_MEM with load_tag=5; memory ack data 0xA -> DATA_ACK to core0, data 0xA, MESI_E.
REQ-022 Core1 load tag 5 while core0 owns it in E -> LOAD_FWD to core0; LOAD_FWDACK data 0xB -> DATA_ACK to core1, 0xB, MESI_S, sharers=2'b11.
REQ-023 Core0 store tag 5 with sharers=2'b11 -> INV_FWD with share_list=2'b10; INV_FWDACK from core1 -> DATA_ACK to core0, MESI_M.
REQ-024 Core1 request during MEM_WAIT -> msg1_ready=0 until the first transaction's DATA_ACK; a stray INV_FWDACK in MEM_WAIT -> no effect.
REQ-025 rst asserted in FWD_WAIT -> next cycle the FSM is IDLE and outputs are at reset values; a subsequent load tag 5 -> LOAD_MEM.
REQ-026 Store by the owner (DIR_EM, owner=source) -> DATA_ACK with MESI_M exactly 2 cycles after acceptance, and no FWD issued.
